// File: rtl/addr_ctrl_pkg.sv
// Shared types and sizing for the serial-address controller.
// Used by addr_ctrl; the increment path is selected with ADDR_AUTOINC_EN.
package addr_ctrl_pkg;

  localparam int DWIDTH_DEF = 21;

  // Counter must hold 2*dw-1, the saturation point for over-long frames.
  function automatic int cnt_width(input int dw);
    return $clog2(2 * dw);
  endfunction

  localparam int BCNT_W = cnt_width(DWIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

endpackage

// File: rtl/addr_ctrl_edge_sync.sv
// Multi-flop synchronizer for an active-low async strobe with a one-cycle
// falling-edge pulse on the synchronized signal. Stages reset to 1 (idle).
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_n,
  output logic fall_pulse
);

  logic [STAGES-1:0] sync_p;
  logic              last_p;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p <= '1;
      last_p <= 1'b1;
    end else begin
      sync_p <= (sync_p << 1) | STAGES'(din_n);
      last_p <= sync_p[STAGES-1];
    end
  end

  assign fall_pulse = last_p & ~sync_p[STAGES-1];

endmodule

// File: rtl/addr_ctrl.sv
// Loads a memory address from a serial frame once the bit count checks out;
// ADDR_AUTOINC_EN adds an MCU-driven increment strobe (inc_n) in IDLE.
module addr_ctrl
  import addr_ctrl_pkg::*;
#(
  parameter int DWIDTH      = DWIDTH_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] sreg_data,
  input  logic              sreg_en,
  input  logic              inc_n,
  output logic [DWIDTH-1:0] addr,
  output logic              addr_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int            CW       = cnt_width(DWIDTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(2 * DWIDTH - 1);
  localparam logic [CW-1:0] CNT_GOOD = CW'(DWIDTH);

  state_t        state, state_nxt;
  logic [CW-1:0] bit_cnt, bit_cnt_nxt;
  logic          inc_pulse;
  logic          load_ok, load_bad, do_inc;

`ifdef ADDR_AUTOINC_EN
  edge_sync #(
    .STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .din_n     (inc_n),
    .fall_pulse(inc_pulse)
  );
`else
  logic unused_inc;
  assign unused_inc = inc_n ^ (SYNC_STAGES > 0);
  assign inc_pulse  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  // Increments are only honoured in IDLE, so a load always wins and a
  // strobe arriving mid-frame is simply lost.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    busy        = 1'b0;
    load_ok     = 1'b0;
    load_bad    = 1'b0;
    do_inc      = 1'b0;
    case (state)
      IDLE: begin
        do_inc = inc_pulse;
        if (!sreg_en) begin
          state_nxt   = SHIFT;
          bit_cnt_nxt = CW'(1);
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (sreg_en) begin
          state_nxt = LOAD;
        end else if (bit_cnt != CNT_MAX) begin
          bit_cnt_nxt = bit_cnt + CW'(1);
        end
      end
      LOAD: begin
        busy      = 1'b1;
        state_nxt = IDLE;
        load_ok   = (bit_cnt == CNT_GOOD);
        load_bad  = (bit_cnt != CNT_GOOD);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr       <= '0;
      addr_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else if (load_ok) begin
      addr       <= sreg_data;
      addr_valid <= 1'b1;
      frame_err  <= 1'b0;
    end else if (load_bad) begin
      frame_err  <= 1'b1;
    end else if (do_inc) begin
      addr       <= addr + DWIDTH'(1);
    end
  end

endmodule
